// File: rtl/dvsd_pe_rr_if.sv
// ---------------------------------------------------------------------------
// dvsd_pe_rr_if
// Handshake bundle for the dvsd_pe_rr priority encoder.
//   Request side : en, mode, in, in_valid (to encoder), in_ready (from encoder)
//   Result side  : out, gs, eno, out_valid (from encoder), out_ready (to encoder)
// Modports:
//   master - the environment that issues request vectors and consumes results
//   slave  - the encoder itself
// ---------------------------------------------------------------------------
interface dvsd_pe_rr_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         en;
  logic         mode;
  logic [N-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         gs;
  logic         eno;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output en, mode, in, in_valid, out_ready,
    input  in_ready, out, gs, eno, out_valid
  );

  modport slave (
    input  en, mode, in, in_valid, out_ready,
    output in_ready, out, gs, eno, out_valid
  );
endinterface

// File: rtl/dvsd_pe_rr.sv
// ---------------------------------------------------------------------------
// dvsd_pe_rr
// Registered N:log2(N) priority encoder with fixed-priority and round-robin
// arbitration, valid/ready handshake on both sides and a one-entry output
// register. Cascade outputs gs/eno follow the classic 8:3 encoder meaning.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-high reset
//   bus   slave modport of dvsd_pe_rr_if (request vector in, encoded result out)
// Parameters:
//   N  number of request inputs (2..64)
//   W  encoded width, derived from N
// ---------------------------------------------------------------------------
module dvsd_pe_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic          clk,
  input logic          reset,
  dvsd_pe_rr_if.slave  bus
);

  logic [W-1:0] r_ptr;        // round-robin search start (next index to favour)
  logic [W-1:0] r_out;
  logic         r_gs;
  logic         r_eno;
  logic         r_out_valid;

  logic         w_accept;
  logic         w_any;
  logic [W-1:0] w_fix_idx;
  logic [W-1:0] w_rr_idx;
  logic         w_rr_found;
  logic [W-1:0] w_idx;
  logic [W-1:0] w_grant;

  // The output register may be refilled in the same cycle it is drained.
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_any        = |bus.in;

  assign bus.out       = r_out;
  assign bus.gs        = r_gs;
  assign bus.eno       = r_eno;
  assign bus.out_valid = r_out_valid;

  // Fixed priority: ascending scan, so the last (highest) set index sticks.
  // Round-robin: descend from r_ptr, wrapping to N-1 after 0; first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before the loops so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_fix_idx  = '0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in[i]) w_fix_idx = W'(i);
    end
    for (int off = 0; off < N; off++) begin
      // Wrap by adding N rather than relying on W-bit overflow, so the
      // search stays inside 0..N-1 for non-power-of-2 N.
      if (int'(r_ptr) >= off) w_idx = W'(int'(r_ptr) - off);
      else                    w_idx = W'(int'(r_ptr) + N - off);
      if (!w_rr_found && bus.in[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_idx;
      end
    end
  end

  assign w_grant = bus.mode ? w_rr_idx : w_fix_idx;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all registers here are control/result flops and get an explicit
  // reset value; a pending result is discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= W'(N - 1);
      r_out       <= '0;
      r_gs        <= 1'b0;
      r_eno       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      if (!bus.en) begin
        r_out <= '0;
        r_gs  <= 1'b0;
        r_eno <= 1'b0;
      end else if (!w_any) begin
        r_out <= '0;
        r_gs  <= 1'b0;
        r_eno <= 1'b1;
      end else begin
        r_out <= w_grant;
        r_gs  <= 1'b1;
        r_eno <= 1'b0;
        // Only round-robin grants move the pointer; it lands one below the
        // winner so the winner becomes lowest priority next time.
        if (bus.mode) begin
          r_ptr <= (w_rr_idx == '0) ? W'(N - 1) : w_rr_idx - W'(1);
        end
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
